hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_if.sv | 33 +++
 rtl/hazard_scoreboard_sb_entry.sv | 26 ++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the two-slot VLIW issue logic.
package hazard_scoreboard_pkg;

  typedef logic [2:0] reg_idx_t;
  typedef logic [1:0] cd_t;

  localparam reg_idx_t REG_ZERO = 3'd0;

  localparam int unsigned S_ALU_LAT_DEF = 1;
  localparam int unsigned LOAD_LAT_DEF  = 1;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } sb_state_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage bundle description and the resulting hold/bubble controls.
interface hazard_scoreboard_if;
  import hazard_scoreboard_pkg::*;

  logic     id_valid;
  logic     id_flush;
  reg_idx_t id_rm;
  reg_idx_t id_rn;
  reg_idx_t id_sm;
  reg_idx_t id_sn;
  reg_idx_t id_rd;
  logic     id_r_regwrite;
  reg_idx_t id_sd;
  logic     id_s_regwrite;
  logic     id_s_memread;
  logic     id_s_memwrite;
  logic     stall;
  logic     bubble;
  logic     stall_start;

  modport master (
    output id_valid, id_flush, id_rm, id_rn, id_sm, id_sn, id_rd,
           id_r_regwrite, id_sd, id_s_regwrite, id_s_memread, id_s_memwrite,
    input  stall, bubble, stall_start
  );

  modport slave (
    input  id_valid, id_flush, id_rm, id_rn, id_sm, id_sn, id_rd,
           id_r_regwrite, id_sd, id_s_regwrite, id_s_memread, id_s_memwrite,
    output stall, bubble, stall_start
  );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// Per-register write countdown: reload on issue, otherwise count down to zero.
module sb_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  cd_t  load_val,
  output logic pending
);

  cd_t cd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd <= '0;
    end else if (load) begin
      cd <= load_val;
    end else if (cd != '0) begin
      cd <= cd - 2'd1;
    end
  end

  assign pending = (cd != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-side hazard scoreboard: holds the ID bundle while an S-slot result
// is still too young to be bypassed into EX.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS     = 8,
  parameter int unsigned S_ALU_LAT = S_ALU_LAT_DEF,
  parameter int unsigned LOAD_LAT  = LOAD_LAT_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  id,
  output logic [NREGS-1:0]    pending,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam cd_t S_ALU_CD = cd_t'(S_ALU_LAT);
  localparam cd_t LOAD_CD  = cd_t'(LOAD_LAT);

  sb_state_t        state;
  sb_state_t        state_next;
  logic             any_hot;
  logic             stall_int;
  logic             issue;
  cd_t              s_lat;
  logic [NREGS-1:0] load_vec;
  cd_t              load_val [NREGS];

  function automatic logic is_hot(input reg_idx_t r, input logic [NREGS-1:0] pend);
    return (r != REG_ZERO) && pend[r];
  endfunction

  always_comb begin
    any_hot = is_hot(id.id_rm, pending) | is_hot(id.id_rn, pending) |
              is_hot(id.id_sm, pending) | is_hot(id.id_sn, pending) |
              (id.id_s_memwrite & is_hot(id.id_sd, pending));
  end

  assign stall_int      = id.id_valid & ~id.id_flush & any_hot;
  assign issue          = id.id_valid & ~id.id_flush & ~stall_int;
  assign s_lat          = id.id_s_memread ? LOAD_CD : S_ALU_CD;
  assign id.stall       = stall_int;
  assign id.bubble      = stall_int;
  assign id.stall_start = stall_int & (state == RUN);

  // S-slot match is tested last so it overrides an R-slot write to the same register.
  always_comb begin
    load_vec = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      load_val[i] = '0;
      if (i != 0) begin
        if (issue && id.id_r_regwrite && (id.id_rd == reg_idx_t'(i))) begin
          load_vec[i] = 1'b1;
          load_val[i] = '0;
        end
        if (issue && id.id_s_regwrite && (id.id_sd == reg_idx_t'(i))) begin
          load_vec[i] = 1'b1;
          load_val[i] = s_lat;
        end
      end
    end
  end

  assign pending[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_entry
    sb_entry u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_vec[g]),
      .load_val (load_val[g]),
      .pending  (pending[g])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (stall_int)  state_next = STALL;
      STALL:   if (!stall_int) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_int && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector scoreboard bench for hazard_scoreboard (plus a narrow-counter copy).
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pending;
  logic [15:0] stall_cycles;
  logic [7:0]  pending_sat;
  logic [1:0]  stall_cycles_sat;

  hazard_scoreboard_if bus ();
  hazard_scoreboard_if bus_sat ();

  hazard_scoreboard #(.NREGS(8), .S_ALU_LAT(1), .LOAD_LAT(1), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id           (bus.slave),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  hazard_scoreboard #(.NREGS(8), .S_ALU_LAT(1), .LOAD_LAT(1), .CNT_W(2)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .id           (bus_sat.slave),
    .pending      (pending_sat),
    .stall_cycles (stall_cycles_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v, f;
    logic [2:0] rm, rn, sm, sn, rd;
    logic rw;
    logic [2:0] sd;
    logic sw, mr, mw;
  } bun_t;

  typedef struct {
    logic        stall;
    logic        start;
    logic [7:0]  pend;
    logic [15:0] cnt;
    bit          chk_state;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  function automatic bun_t mk(input logic v, f, input logic [2:0] rm, rn, sm, sn, rd,
                              input logic rw, input logic [2:0] sd,
                              input logic sw, mr, mw);
    bun_t b;
    b = '{v:v, f:f, rm:rm, rn:rn, sm:sm, sn:sn, rd:rd, rw:rw, sd:sd, sw:sw, mr:mr, mw:mw};
    return b;
  endfunction

  function automatic bun_t rd_src(input logic [2:0] rm, rn, sm, sn);
    return mk(1, 0, rm, rn, sm, sn, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bun_t s_wr(input logic [2:0] sd, input logic mr);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, sd, 1, mr, 0);
  endfunction

  task automatic drive(input bun_t b);
    bus.id_valid      = b.v;   bus_sat.id_valid      = b.v;
    bus.id_flush      = b.f;   bus_sat.id_flush      = b.f;
    bus.id_rm         = b.rm;  bus_sat.id_rm         = b.rm;
    bus.id_rn         = b.rn;  bus_sat.id_rn         = b.rn;
    bus.id_sm         = b.sm;  bus_sat.id_sm         = b.sm;
    bus.id_sn         = b.sn;  bus_sat.id_sn         = b.sn;
    bus.id_rd         = b.rd;  bus_sat.id_rd         = b.rd;
    bus.id_r_regwrite = b.rw;  bus_sat.id_r_regwrite = b.rw;
    bus.id_sd         = b.sd;  bus_sat.id_sd         = b.sd;
    bus.id_s_regwrite = b.sw;  bus_sat.id_s_regwrite = b.sw;
    bus.id_s_memread  = b.mr;  bus_sat.id_s_memread  = b.mr;
    bus.id_s_memwrite = b.mw;  bus_sat.id_s_memwrite = b.mw;
  endtask

  task automatic expect_now(input logic s, st_exp, input logic [7:0] p, input logic [15:0] c,
                            input bit cs, input logic sv);
    exp_t e;
    e.stall = s; e.start = st_exp; e.pend = p; e.cnt = c; e.chk_state = cs; e.st = sv;
    q.push_back(e);
  endtask

  // One bundle for one cycle; expectations describe what is visible before the next edge.
  task automatic step(input bun_t b, input logic s, st_exp, input logic [7:0] p,
                      input logic [15:0] c, input bit cs = 0, input logic sv = 0);
    drive(b);
    expect_now(s, st_exp, p, c, cs, sv);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) -> sample_ev;

  initial begin : monitor
    exp_t e;
    logic [15:0] sat_exp;
    forever begin
      @(sample_ev);
      if (q.size() != 0) begin
        e = q.pop_front();
        sat_exp = (e.cnt > 16'd3) ? 16'd3 : e.cnt;
        chk("stall",            {31'd0, bus.stall},       {31'd0, e.stall});
        chk("bubble",           {31'd0, bus.bubble},      {31'd0, e.stall});
        chk("stall_start",      {31'd0, bus.stall_start}, {31'd0, e.start});
        chk("pending",          {24'd0, pending},         {24'd0, e.pend});
        chk("stall_cycles",     {16'd0, stall_cycles},    {16'd0, e.cnt});
        chk("sat_stall",        {31'd0, bus_sat.stall},   {31'd0, e.stall});
        chk("sat_pending",      {24'd0, pending_sat},     {24'd0, e.pend});
        chk("sat_stall_cycles", {30'd0, stall_cycles_sat}, {16'd0, sat_exp});
        if (e.chk_state) chk("state", {31'd0, logic'(dut.state)}, {31'd0, e.st});
      end
    end
  end

  initial begin : stimulus
    bun_t nop;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    drive(nop);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(nop,                   0, 0, 8'h00, 0, 1, RUN);
    // Load r3, immediate consumer on Rm: exactly one stall cycle.
    step(s_wr(3, 1),            0, 0, 8'h00, 0);
    step(rd_src(3, 0, 0, 0),    1, 1, 8'h08, 0);
    step(rd_src(3, 0, 0, 0),    0, 0, 8'h00, 1, 1, STALL);
    // R-slot ALU result is bypassed from EX/MEM.
    step(mk(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0), 0, 0, 8'h00, 1);
    step(rd_src(0, 0, 0, 5),    0, 0, 8'h00, 1);
    // Store data read through id_sd.
    step(s_wr(2, 0),            0, 0, 8'h00, 1);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1), 1, 1, 8'h04, 1);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1), 0, 0, 8'h00, 2);
    // id_sd as destination only is not a source.
    step(s_wr(2, 0),            0, 0, 8'h00, 2);
    step(s_wr(2, 0),            0, 0, 8'h04, 2);
    step(nop,                   0, 0, 8'h04, 2);
    // Both slots write r4; the S-slot load latency must win.
    step(mk(1, 0, 0, 0, 0, 0, 4, 1, 4, 1, 1, 0), 0, 0, 8'h00, 2);
    step(rd_src(0, 4, 0, 0),    1, 1, 8'h10, 2);
    step(rd_src(0, 4, 0, 0),    0, 0, 8'h00, 3);
    // Register zero never becomes pending.
    step(s_wr(0, 1),            0, 0, 8'h00, 3);
    step(rd_src(0, 0, 0, 0),    0, 0, 8'h00, 3);
    // Flushed bundle: no stall despite a hot source, and its load is not recorded.
    step(s_wr(1, 1),            0, 0, 8'h00, 3);
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 6, 1, 1, 0), 0, 0, 8'h02, 3);
    step(rd_src(0, 0, 6, 0),    0, 0, 8'h00, 3);
    // Fourth stall: narrow counter saturates at 3.
    step(s_wr(7, 1),            0, 0, 8'h00, 3);
    step(rd_src(0, 0, 7, 0),    1, 1, 8'h80, 3);
    step(rd_src(0, 0, 7, 0),    0, 0, 8'h00, 4);
    step(s_wr(7, 1),            0, 0, 8'h00, 4);

    // Asynchronous reset in the middle of an active stall.
    drive(rd_src(7, 0, 0, 0));
    expect_now(1, 1, 8'h80, 4, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(0, 0, 8'h00, 0, 1, RUN);
    -> sample_ev;
    @(posedge clk);
    #1;
    step(rd_src(7, 0, 0, 0),    0, 0, 8'h00, 0, 1, RUN);
    rst_n = 1'b1;

    step(s_wr(3, 1),            0, 0, 8'h00, 0);
    step(rd_src(3, 0, 0, 0),    1, 1, 8'h08, 0);
    step(rd_src(3, 0, 0, 0),    0, 0, 8'h00, 1);
    step(nop,                   0, 0, 8'h00, 1);

    repeat (5) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
